// File: rtl/conv_layer_feature_writer.sv
// conv_layer_feature_writer
//   Takes finished feature rows from the conv layer and writes them into external
//   feature RAM, one word per cycle. A 2-entry row FIFO plus the output shift register
//   means up to three rows can be in flight, so the conv pipeline never has to stall.
//   The block pulses image_write_done once every row of an image has been committed.
// Ports
//   clk              : clock, rising edge
//   rst_n            : asynchronous reset, ACTIVE-HIGH despite the name
//   row_valid        : 1-cycle strobe, feature_idx/feature_row/feature_in valid
//   feature_idx      : feature map index of the row
//   feature_row      : row index within the map
//   feature_in       : row data, column 0 in the most significant word
//   image_calc_fin   : 1-cycle strobe, last row of the image has been issued
//   row_ready        : FIFO has a free slot (registered, informational only)
//   ext_ram_we       : RAM write enable
//   ext_ram_addr     : RAM write address
//   ext_ram_data     : RAM write data
//   image_write_done : 1-cycle pulse, every row of the image has been written
//   err              : sticky, a row was dropped (FIFO full or row out of range)
module conv_layer_feature_writer #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ARRAY_SIZE     = 6,
  parameter int          ROWS           = 6,
  parameter int          EXT_ADDR_WIDTH = 16,
  parameter int unsigned BASE_ADDR      = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           row_valid,
  input  logic [1:0]                     feature_idx,
  input  logic [2:0]                     feature_row,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature_in,
  input  logic                           image_calc_fin,
  output logic                           row_ready,
  output logic                           ext_ram_we,
  output logic [EXT_ADDR_WIDTH-1:0]      ext_ram_addr,
  output logic [DATA_WIDTH-1:0]          ext_ram_data,
  output logic                           image_write_done,
  output logic                           err
);

  localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int CNT_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  typedef struct packed {
    logic [1:0]       idx;
    logic [2:0]       row;
    logic [ROW_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                    state, state_next;
  entry_t                    fifo_q [2];
  entry_t                    entry_in;
  logic [1:0]                count, count_next;
  logic                      empty, full, in_range, push, pop, drop, last;
  logic                      fin_pending;
  logic [ROW_W-1:0]          shreg;
  logic [CNT_W-1:0]          cnt;
  logic [EXT_ADDR_WIDTH-1:0] addr_calc;

  assign entry_in  = '{idx: feature_idx, row: feature_row, data: feature_in};
  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign in_range  = (int'(feature_row) < ROWS);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push      = row_valid && in_range && (!full || pop);
  assign drop      = row_valid && !push;
  assign last      = (cnt == CNT_W'(ARRAY_SIZE - 1));
  assign addr_calc = EXT_ADDR_WIDTH'(BASE_ADDR +
                     (int'(fifo_q[0].idx) * ROWS + int'(fifo_q[0].row)) * ARRAY_SIZE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    pop              = 1'b0;
    image_write_done = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end else if (fin_pending) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        if (last) begin
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end
      end
      DONE: begin
        image_write_done = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (pop && !push) count_next = count - 2'd1;
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      count     <= '0;
      row_ready <= 1'b1;
    end else begin
      case ({push, pop})
        2'b10: fifo_q[count[0]] <= entry_in;
        2'b01: fifo_q[0] <= fifo_q[1];
        2'b11: begin
          if (count == 2'd1) begin
            fifo_q[0] <= entry_in;
          end else begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= entry_in;
          end
        end
        default: ;
      endcase
      count     <= count_next;
      row_ready <= (count_next != 2'd2);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)               fin_pending <= 1'b0;
    else if (image_calc_fin) fin_pending <= 1'b1;
    else if (state == DONE)  fin_pending <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) err <= 1'b0;
    else       err <= err | drop;
  end

  // Output word 0 is loaded at the pop itself; the shift register holds the rest.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ext_ram_we   <= 1'b0;
      ext_ram_addr <= '0;
      ext_ram_data <= '0;
      shreg        <= '0;
      cnt          <= '0;
    end else if (pop) begin
      ext_ram_we   <= 1'b1;
      ext_ram_addr <= addr_calc;
      ext_ram_data <= fifo_q[0].data[ROW_W-1 -: DATA_WIDTH];
      shreg        <= fifo_q[0].data << DATA_WIDTH;
      cnt          <= '0;
    end else if (state == WRITE) begin
      if (!last) begin
        ext_ram_addr <= ext_ram_addr + 1'b1;
        ext_ram_data <= shreg[ROW_W-1 -: DATA_WIDTH];
        shreg        <= shreg << DATA_WIDTH;
        cnt          <= cnt + 1'b1;
      end else begin
        ext_ram_we <= 1'b0;
      end
    end
  end

endmodule
